// File: rtl/jt34061_arb.sv
// VRAM cycle arbiter for the 34061-style video controller: shares the DRAM between
// shift-register transfers, refresh and host accesses, one fixed-length cycle at a time.
module jt34061_arb #(
  parameter int unsigned CYC_LEN     = 4,  // memory-cycle length in cen ticks (2..15)
  parameter int unsigned RFSH_URGENT = 4   // pending refreshes at which refresh beats host
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       srt_req,
  input  logic [9:0] srt_row,
  input  logic       rfsh_tick,
  input  logic       host_req,
  input  logic [9:0] host_row,
  output logic       ram_cyc,
  output logic [1:0] ram_op,
  output logic [9:0] ram_row,
  output logic       host_ack,
  output logic       srt_done,
  output logic [2:0] rfsh_pend,
  output logic       rfsh_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOST = 2'd1,
    RFSH = 2'd2,
    SRT  = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(CYC_LEN - 1);

  state_t     state;
  state_t     grant;
  logic [3:0] cnt;
  logic       srt_pend;
  logic [9:0] srt_row_l;
  logic [9:0] rfsh_addr;
  logic       rfsh_urgent;
  logic       rfsh_grant;

  assign ram_op      = state;
  assign rfsh_urgent = 32'(rfsh_pend) >= RFSH_URGENT;
  assign rfsh_grant  = (state == IDLE) && (grant == RFSH);

  // Fixed priority: video transfer, urgent refresh, host, background refresh.
  always_comb begin
    grant = IDLE;
    if (srt_pend)              grant = SRT;
    else if (rfsh_urgent)      grant = RFSH;
    else if (host_req)         grant = HOST;
    else if (rfsh_pend != 3'd0) grant = RFSH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ram_cyc   <= 1'b0;
      ram_row   <= 10'd0;
      host_ack  <= 1'b0;
      srt_done  <= 1'b0;
      srt_pend  <= 1'b0;
      srt_row_l <= 10'd0;
      rfsh_addr <= 10'd0;
      rfsh_pend <= 3'd0;
      rfsh_ovf  <= 1'b0;
    end else begin
      // NOTE: completion pulses default low on every clk, not only on cen, so each lasts one clk.
      host_ack <= 1'b0;
      srt_done <= 1'b0;
      if (cen) begin
        if (srt_req) begin
          srt_pend  <= 1'b1;
          srt_row_l <= srt_row;
        end
        case (state)
          IDLE: begin
            if (grant != IDLE) begin
              state   <= grant;
              ram_cyc <= 1'b1;
              cnt     <= CNT_LOAD;
              case (grant)
                SRT: begin
                  ram_row  <= srt_row_l;
                  // A request landing on the grant tick stays pending for the next frame line.
                  srt_pend <= srt_req;
                end
                RFSH:    ram_row <= rfsh_addr;
                default: ram_row <= host_row;
              endcase
            end
          end
          default: begin
            if (cnt == 4'd0) begin
              state    <= IDLE;
              ram_cyc  <= 1'b0;
              host_ack <= (state == HOST);
              srt_done <= (state == SRT);
              if (state == RFSH) rfsh_addr <= rfsh_addr + 10'd1;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
        endcase
        // A tick and a refresh grant on the same cen cancel each other out.
        if (rfsh_tick && !rfsh_grant) begin
          if (rfsh_pend == 3'd7) rfsh_ovf  <= 1'b1;
          else                   rfsh_pend <= rfsh_pend + 3'd1;
        end else if (!rfsh_tick && rfsh_grant) begin
          rfsh_pend <= rfsh_pend - 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jt34061_arb.sv
// Directed bench for jt34061_arb: expected grants are queued as stimulus is applied and
// matched against the cycles the arbiter actually starts.
module tb_jt34061_arb;

  localparam int CYC_LEN = 4;

  logic       clk, rst, cen;
  logic       srt_req, rfsh_tick, host_req;
  logic [9:0] srt_row, host_row;
  logic       ram_cyc, host_ack, srt_done, rfsh_ovf;
  logic [1:0] ram_op;
  logic [9:0] ram_row;
  logic [2:0] rfsh_pend;

  jt34061_arb #(.CYC_LEN(CYC_LEN), .RFSH_URGENT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .srt_req  (srt_req),
    .srt_row  (srt_row),
    .rfsh_tick(rfsh_tick),
    .host_req (host_req),
    .host_row (host_row),
    .ram_cyc  (ram_cyc),
    .ram_op   (ram_op),
    .ram_row  (ram_row),
    .host_ack (host_ack),
    .srt_done (srt_done),
    .rfsh_pend(rfsh_pend),
    .rfsh_ovf (rfsh_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [9:0] row;
    int         gap;   // required idle ticks before this grant, 0 = don't care
  } want_t;

  want_t      want_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [1:0] prev_op = 2'd0;
  int         run_len = 0;
  int         idle_len = 100;
  logic [9:0] last_row = 10'd0;
  logic [9:0] m_addr = 10'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic push_want(input logic [1:0] op, input logic [9:0] row, input int gap);
    want_t w;
    w.op  = op;
    w.row = row;
    w.gap = gap;
    want_q.push_back(w);
  endtask

  task automatic push_rfsh(input int gap);
    push_want(2'd2, m_addr, gap);
    m_addr = m_addr + 10'd1;
  endtask

  // Called just after every cen edge.
  task automatic monitor();
    logic  endc;
    want_t w;
    endc = (prev_op != 2'd0) && (ram_op == 2'd0);
    check("ram_cyc", ram_cyc, ram_op != 2'd0);
    check("host_ack", host_ack, endc && (prev_op == 2'd1));
    check("srt_done", srt_done, endc && (prev_op == 2'd3));
    if (prev_op == 2'd0 && ram_op != 2'd0) begin
      if (want_q.size() == 0) begin
        check("unexpected_grant", ram_op, 2'd0);
      end else begin
        w = want_q.pop_front();
        check("grant_op", ram_op, w.op);
        check("grant_row", ram_row, w.row);
        if (w.gap != 0) check("idle_gap", idle_len, w.gap);
      end
      last_row = ram_row;
      run_len  = 1;
    end else if (ram_op != 2'd0) begin
      check("no_switch", ram_op, prev_op);
      run_len++;
      check("cyc_len_max", run_len <= CYC_LEN, 1'b1);
    end else begin
      if (endc) check("cyc_len", run_len, CYC_LEN);
      check("row_hold", ram_row, last_row);
    end
    idle_len = (ram_op != 2'd0) ? 0 : ((prev_op == 2'd0) ? idle_len + 1 : 1);
    prev_op  = ram_op;
    if (host_ack) host_req = 1'b0;
  endtask

  // One cen tick followed by one clk without cen.
  task automatic tick();
    logic [1:0] op_s;
    cen = 1'b1;
    @(posedge clk); #1;
    srt_req   = 1'b0;
    rfsh_tick = 1'b0;
    cen       = 1'b0;
    monitor();
    op_s = ram_op;
    @(posedge clk); #1;
    check("pulse_width", {host_ack, srt_done}, 2'b00);
    check("cen_hold", ram_op, op_s);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cen = 1'b0; srt_req = 1'b0; rfsh_tick = 1'b0; host_req = 1'b0;
    srt_row = 10'd0; host_row = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ram_cyc", ram_cyc, 1'b0);
    check("rst_ram_op", ram_op, 2'd0);
    check("rst_ram_row", ram_row, 10'd0);
    check("rst_pulses", {host_ack, srt_done}, 2'b00);
    check("rst_pend", rfsh_pend, 3'd0);
    check("rst_ovf", rfsh_ovf, 1'b0);
    rst = 1'b0;

    // Host alone, request dropped right after grant: cycle still completes with an ack.
    host_req = 1'b1; host_row = 10'h2A3;
    push_want(2'd1, 10'h2A3, 0);
    tick();
    host_req = 1'b0;
    run(6);
    check("host_early_drop_done", want_q.size(), 0);

    // Host held until acknowledged.
    host_req = 1'b1; host_row = 10'h0F0;
    push_want(2'd1, 10'h0F0, 0);
    run(7);
    check("host_held_done", want_q.size(), 0);
    check("host_req_dropped", host_req, 1'b0);

    // Pulses presented without cen must be ignored.
    cen = 1'b0; rfsh_tick = 1'b1; srt_req = 1'b1; srt_row = 10'h3FF;
    repeat (3) @(posedge clk);
    #1;
    rfsh_tick = 1'b0; srt_req = 1'b0;
    check("cen_gate_pend", rfsh_pend, 3'd0);
    run(3);
    check("cen_gate_idle", ram_op, 2'd0);

    // Two SRT requests during a host cycle: one SRT with the latest row after one idle tick.
    host_req = 1'b1; host_row = 10'h111;
    push_want(2'd1, 10'h111, 0);
    tick();
    srt_req = 1'b1; srt_row = 10'h100;
    tick();
    srt_req = 1'b1; srt_row = 10'h155;
    tick();
    push_want(2'd3, 10'h155, 1);
    run(9);
    check("srt_after_host_done", want_q.size(), 0);

    // Urgent refresh beats host at pend=4; host beats refresh at pend=3.
    host_req = 1'b1; host_row = 10'h0AA;
    push_want(2'd1, 10'h0AA, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      rfsh_tick = 1'b1;
      tick();
    end
    check("pend_urgent", rfsh_pend, 3'd4);
    host_req = 1'b1; host_row = 10'h0BB;
    push_rfsh(1);
    push_want(2'd1, 10'h0BB, 1);
    push_rfsh(1);
    push_rfsh(1);
    push_rfsh(1);
    tick();
    check("pend_after_urgent", rfsh_pend, 3'd3);
    run(26);
    check("prio_done", want_q.size(), 0);
    check("prio_pend_drained", rfsh_pend, 3'd0);

    // Saturation and overflow while SRTs keep the arbiter busy.
    srt_row = 10'h3C3;
    push_want(2'd3, 10'h3C3, 0);
    push_want(2'd3, 10'h3C3, 1);
    push_want(2'd3, 10'h3C3, 1);
    for (int i = 0; i < 7; i++) begin
      srt_req = 1'b1; rfsh_tick = 1'b1;
      tick();
    end
    check("pend_sat7", rfsh_pend, 3'd7);
    check("ovf_before", rfsh_ovf, 1'b0);
    srt_req = 1'b1; rfsh_tick = 1'b1;
    tick();
    check("pend_after_ovf", rfsh_pend, 3'd7);
    check("ovf_set", rfsh_ovf, 1'b1);
    run(8);
    for (int i = 0; i < 8; i++) push_rfsh(1);
    rfsh_tick = 1'b1;
    tick();
    check("pend_tick_on_grant", rfsh_pend, 3'd7);
    run(41);
    check("drain_done", want_q.size(), 0);
    check("drain_pend", rfsh_pend, 3'd0);
    check("ovf_sticky", rfsh_ovf, 1'b1);

    // Walk the refresh address all the way round; the last grant must be row 0 again.
    for (int i = 0; i < 1013; i++) begin
      push_rfsh(0);
      rfsh_tick = 1'b1;
      tick();
      run(5);
    end
    check("wrap_done", want_q.size(), 0);

    // Reset in the middle of an SRT cycle.
    srt_row = 10'h2AA; srt_req = 1'b1;
    push_want(2'd3, 10'h2AA, 0);
    tick();
    rfsh_tick = 1'b1;
    tick();
    tick();
    check("pre_rst_op", ram_op, 2'd3);
    check("pre_rst_pend", rfsh_pend, 3'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_cyc", ram_cyc, 1'b0);
    check("mid_rst_op", ram_op, 2'd0);
    check("mid_rst_pend", rfsh_pend, 3'd0);
    check("mid_rst_ovf", rfsh_ovf, 1'b0);
    check("mid_rst_done", srt_done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    want_q.delete();
    prev_op = 2'd0; run_len = 0; idle_len = 100; last_row = 10'd0; m_addr = 10'd0;
    run(8);
    check("post_rst_idle", ram_op, 2'd0);
    check("post_rst_pend", rfsh_pend, 3'd0);

    // First refresh after reset must start again from row 0.
    push_rfsh(0);
    rfsh_tick = 1'b1;
    tick();
    run(5);
    check("post_rst_rfsh_done", want_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jt34061_arb.md
JT34061_ARB -- requirements
Module: jt34061_arb

Interface
REQ-001 SHALL have parameter CYC_LEN, default 4, meaning memory-cycle length in cen ticks (legal range 2..15).
REQ-002 SHALL have parameter RFSH_URGENT, default 4, meaning the pending-refresh count at which refresh overrides host.
REQ-003 SHALL have input clk, 1 bit: clock.
REQ-004 SHALL have input rst, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have input cen, 1 bit: clock enable; all state advances only on clk edges with cen=1.
REQ-006 SHALL have input srt_req, 1 bit: shift-register-transfer request pulse from the video timing generator.
REQ-007 SHALL have input srt_row, 10 bits: VRAM row for the transfer, sampled when srt_req=1.
REQ-008 SHALL have input rfsh_tick, 1 bit: refresh-interval pulse.
REQ-009 SHALL have input host_req, 1 bit: level request held by the host until acknowledged.
REQ-010 SHALL have input host_row, 10 bits: host row address, stable while host_req=1.
REQ-011 SHALL have output ram_cyc, 1 bit: high for the whole duration of a memory cycle.
REQ-012 SHALL have output ram_op, 2 bits: 0 = idle, 1 = host, 2 = refresh, 3 = SRT.
REQ-013 SHALL have output ram_row, 10 bits: row address for the current cycle.
REQ-014 SHALL have outputs host_ack and srt_done, 1 bit each: one-clk completion pulses.
REQ-015 SHALL have output rfsh_pend, 3 bits: pending refresh count.
REQ-016 SHALL have output rfsh_ovf, 1 bit: sticky refresh-overflow flag.

Function
REQ-017 SHALL implement states IDLE, SRT, RFSH and HOST; ram_op SHALL encode the state.
REQ-018 In IDLE on cen, grant priority SHALL be: pending SRT; then refresh if rfsh_pend>=RFSH_URGENT; then host_req; then refresh if rfsh_pend>0; else remain IDLE.
REQ-019 A granted state SHALL hold for exactly CYC_LEN cen ticks; a 4-bit down-counter loads CYC_LEN-1 at grant, and the state returns to IDLE on the tick at which the counter reads 0.
REQ-020 ram_cyc SHALL be 1 exactly while the state is not IDLE; back-to-back cycles SHALL have one IDLE cen tick between them.
REQ-021 ram_row SHALL be latched at grant: srt_row_l for SRT, rfsh_addr for RFSH, host_row for HOST; it SHALL hold its value while IDLE.
REQ-022 srt_req SHALL set an srt_pend flag and latch srt_row_l in any state; a second srt_req before service SHALL overwrite srt_row_l and leave a single pending request.
REQ-023 srt_pend SHALL clear at SRT grant; srt_req coincident with that grant SHALL re-set srt_pend.
REQ-024 rfsh_tick SHALL increment rfsh_pend, saturating at 7; a tick arriving while rfsh_pend=7 SHALL set rfsh_ovf, which clears only on rst.
REQ-025 A RFSH grant SHALL decrement rfsh_pend; a simultaneous rfsh_tick SHALL leave rfsh_pend unchanged.
REQ-026 rfsh_addr (10 bits, internal) SHALL increment at the end of each RFSH cycle and wrap from 1023 to 0.
REQ-027 host_ack SHALL pulse for one clk on the final tick of a HOST cycle; srt_done SHALL pulse likewise for SRT; RFSH cycles produce no pulse.
REQ-028 Deasserting host_req mid-cycle SHALL NOT abort the cycle; host_ack SHALL still pulse.
REQ-029 rfsh_tick and srt_req SHALL be sampled only when cen=1.

Reset
REQ-030 rst SHALL asynchronously force state IDLE, ram_cyc=0, ram_op=0, ram_row=0, host_ack=0, srt_done=0, rfsh_pend=0, rfsh_ovf=0, rfsh_addr=0, srt_pend=0 and counter=0.
REQ-031 rst asserted mid-cycle SHALL abort the cycle with no ack or done pulse; after release the arbiter SHALL start from IDLE with no pending work.

Verification
REQ-032 host_req=1 alone, CYC_LEN=4 -> grant on the next cen; ram_op=1 for 4 cen ticks; host_ack pulses once; ram_row=host_row.
REQ-033 srt_req with srt_row=0x155 during a HOST cycle -> host completes, then one IDLE tick, then ram_op=3 with ram_row=0x155 and a single srt_done.
REQ-034 rfsh_pend=4 with host_req=1 -> RFSH granted before HOST; with rfsh_pend=3 -> HOST granted first.
REQ-035 8 rfsh_ticks with no grants -> rfsh_pend=7 and rfsh_ovf=1; a further tick coincident with a RFSH grant -> rfsh_pend stays at 7.
REQ-036 1024 refresh cycles -> rfsh_addr returns to 0.
REQ-037 rst pulsed mid-SRT -> ram_cyc=0 immediately, no srt_done, rfsh_pend=0.
